// File: rtl/sweep_scheduler.sv
// -----------------------------------------------------------------------------
// sweep_scheduler
//
// Frequency-sweep sequencer feeding the DDS phase accumulator. A sweep steps a
// frequency from a start value to a stop value in fixed increments. Each value
// is offered to the DDS over a valid/ready handshake and, once accepted, held
// for a programmable dwell before the next value is offered.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cfg_start_freq    first frequency of the sweep
//   cfg_stop_freq     end frequency of the sweep
//   cfg_step          frequency increment per step (0 = single-point sweep)
//   cfg_dwell         cycles each value is held after acceptance (0 acts as 1)
//   cfg_mode          00 single, 01 repeat, 10 up-down, 11 single
//   start             one-cycle pulse, begins a sweep when idle
//   abort             one-cycle pulse, ends a sweep (wins over start)
//   inc_ready         DDS accepts freq_out/phase_inc this cycle
//   inc_valid         freq_out/phase_inc hold a new value
//   freq_out          current sweep frequency
//   phase_inc         freq_out * INC_SCALE, truncated to PINC_W
//   busy              sweep in progress
//   done              one-cycle pulse at the end of a single sweep
//   state_dbg         FSM state: 0 IDLE, 1 PRESENT, 2 DWELL
//
// Handshake: a value transfers on every cycle where inc_valid and inc_ready
// are both high. While inc_valid is high and inc_ready is low, freq_out and
// phase_inc do not change and inc_valid stays high. inc_valid never depends
// combinationally on inc_ready.
// -----------------------------------------------------------------------------
module sweep_scheduler #(
  parameter int FREQ_W    = 16,
  parameter int DWELL_W   = 24,
  parameter int INC_SCALE = 2,
  parameter int PINC_W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  input  logic               inc_ready,
  output logic               inc_valid,
  output logic [FREQ_W-1:0]  freq_out,
  output logic [PINC_W-1:0]  phase_inc,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_DWELL   = 2'd2
  } state_e;

  localparam logic [1:0]         MODE_REPEAT = 2'b01;
  localparam logic [1:0]         MODE_UPDOWN = 2'b10;
  localparam logic [PINC_W-1:0]  SCALE       = PINC_W'(INC_SCALE);
  localparam logic [DWELL_W-1:0] DWELL_ONE   = DWELL_W'(1);

  state_e              state_q, state_d;
  logic [FREQ_W-1:0]   sw_start_q, sw_start_d;
  logic [FREQ_W-1:0]   sw_stop_q, sw_stop_d;
  logic [FREQ_W-1:0]   sw_step_q, sw_step_d;
  logic [DWELL_W-1:0]  sw_dwell_q, sw_dwell_d;
  logic [1:0]          sw_mode_q, sw_mode_d;
  logic                dir_up_q, dir_up_d;
  logic [FREQ_W-1:0]   cur_q, cur_d;
  logic [PINC_W-1:0]   pinc_q, pinc_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic                done_q, done_d;
  logic                load_cur;
  logic [FREQ_W-1:0]   next_freq;

  // One step from cur toward target, clamped at target. Done one bit wider
  // so neither the sum nor the difference can wrap.
  function automatic logic [FREQ_W-1:0] step_toward(
    input logic [FREQ_W-1:0] cur,
    input logic [FREQ_W-1:0] target,
    input logic [FREQ_W-1:0] step,
    input logic              up
  );
    logic [FREQ_W:0] sum;
    logic [FREQ_W:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, target};
    if (up) begin
      step_toward = (sum >= {1'b0, target}) ? target : sum[FREQ_W-1:0];
    end else begin
      step_toward = (diff <= {1'b0, step}) ? target : (cur - step);
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    sw_start_d  = sw_start_q;
    sw_stop_d   = sw_stop_q;
    sw_step_d   = sw_step_q;
    sw_dwell_d  = sw_dwell_q;
    sw_mode_d   = sw_mode_q;
    dir_up_d    = dir_up_q;
    dwell_cnt_d = dwell_cnt_q;
    done_d      = 1'b0;
    load_cur    = 1'b0;
    next_freq   = cur_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          sw_start_d = cfg_start_freq;
          // A zero step can never reach a distinct stop value, so collapse
          // the sweep to its start point.
          sw_stop_d  = (cfg_step == '0) ? cfg_start_freq : cfg_stop_freq;
          sw_step_d  = cfg_step;
          sw_dwell_d = cfg_dwell;
          sw_mode_d  = cfg_mode;
          dir_up_d   = (cfg_start_freq <= cfg_stop_freq);
          next_freq  = cfg_start_freq;
          load_cur   = 1'b1;
          state_d    = S_PRESENT;
        end
      end

      S_PRESENT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (inc_ready) begin
          dwell_cnt_d = (sw_dwell_q == '0) ? DWELL_ONE : sw_dwell_q;
          state_d     = S_DWELL;
        end
      end

      S_DWELL: begin
        if (abort) begin
          dwell_cnt_d = '0;
          state_d     = S_IDLE;
        end else if (dwell_cnt_q <= DWELL_ONE) begin
          dwell_cnt_d = '0;
          state_d     = S_PRESENT;
          load_cur    = 1'b1;
          if (cur_q != sw_stop_q) begin
            next_freq = step_toward(cur_q, sw_stop_q, sw_step_q, dir_up_q);
          end else begin
            case (sw_mode_q)
              MODE_REPEAT: next_freq = sw_start_q;
              MODE_UPDOWN: begin
                // Endpoints swap and the first value of the new leg is one
                // step away from the endpoint just presented.
                sw_start_d = sw_stop_q;
                sw_stop_d  = sw_start_q;
                dir_up_d   = !dir_up_q;
                next_freq  = step_toward(cur_q, sw_start_q, sw_step_q, !dir_up_q);
              end
              default: begin
                load_cur = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
              end
            endcase
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // freq_out and phase_inc always update together so the DDS never sees a
    // mismatched pair.
    cur_d  = load_cur ? next_freq : cur_q;
    pinc_d = load_cur ? (PINC_W'(next_freq) * SCALE) : pinc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sw_start_q  <= '0;
      sw_stop_q   <= '0;
      sw_step_q   <= '0;
      sw_dwell_q  <= '0;
      sw_mode_q   <= '0;
      dir_up_q    <= 1'b0;
      cur_q       <= '0;
      pinc_q      <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_start_q  <= sw_start_d;
      sw_stop_q   <= sw_stop_d;
      sw_step_q   <= sw_step_d;
      sw_dwell_q  <= sw_dwell_d;
      sw_mode_q   <= sw_mode_d;
      dir_up_q    <= dir_up_d;
      cur_q       <= cur_d;
      pinc_q      <= pinc_d;
      dwell_cnt_q <= dwell_cnt_d;
      done_q      <= done_d;
    end
  end

  assign inc_valid = (state_q == S_PRESENT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign freq_out  = cur_q;
  assign phase_inc = pinc_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sweep_scheduler
//
// Directed and randomized sweeps against a reference model that lists the
// expected frequency sequence leg by leg. Every accepted value is compared
// with the model; step period, hold stability, done/busy timing, abort and
// asynchronous reset are checked around it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sweep_scheduler;

  localparam int FREQ_W    = 16;
  localparam int DWELL_W   = 24;
  localparam int INC_SCALE = 2;
  localparam int PINC_W    = 20;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FREQ_W-1:0]  cfg_start_freq;
  logic [FREQ_W-1:0]  cfg_stop_freq;
  logic [FREQ_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic               start;
  logic               abort;
  logic               inc_ready;
  logic               inc_valid;
  logic [FREQ_W-1:0]  freq_out;
  logic [PINC_W-1:0]  phase_inc;
  logic               busy;
  logic               done;
  logic [1:0]         state_dbg;

  sweep_scheduler #(
    .FREQ_W(FREQ_W), .DWELL_W(DWELL_W), .INC_SCALE(INC_SCALE), .PINC_W(PINC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .start(start), .abort(abort), .inc_ready(inc_ready),
    .inc_valid(inc_valid), .freq_out(freq_out), .phase_inc(phase_inc),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Documented debug encoding of state_dbg.
  localparam logic [31:0] DBG_IDLE = 32'd0;
  localparam logic [31:0] DBG_PRES = 32'd1;
  localparam logic [31:0] DBG_DWEL = 32'd2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [FREQ_W-1:0] exp_q[$];

  function automatic logic [31:0] pinc_of(input int f);
    return 32'((f * INC_SCALE) % (1 << PINC_W));
  endfunction

  // One leg a -> b: a, a+-step, ... while strictly short of b, then b itself.
  function automatic void push_leg(input int a, input int b, input int st, input bit skip_first);
    int k;
    if (st == 0 || a == b) begin
      exp_q.push_back(FREQ_W'(a));
      return;
    end
    k = skip_first ? 1 : 0;
    if (a < b) begin
      while (a + k * st < b) begin exp_q.push_back(FREQ_W'(a + k * st)); k++; end
    end else begin
      while (a - k * st > b) begin exp_q.push_back(FREQ_W'(a - k * st)); k++; end
    end
    exp_q.push_back(FREQ_W'(b));
  endfunction

  function automatic void build_model(input int s, input int e, input int st,
                                      input logic [1:0] md, input int n);
    bit fwd;
    exp_q.delete();
    if (st == 0) e = s;
    if (md == 2'b01) begin
      while (exp_q.size() < n) push_leg(s, e, st, 1'b0);
    end else if (md == 2'b10) begin
      push_leg(s, e, st, 1'b0);
      fwd = 1'b0;
      while (exp_q.size() < n) begin
        if (fwd) push_leg(s, e, st, 1'b1);
        else     push_leg(e, s, st, 1'b1);
        fwd = !fwd;
      end
    end else begin
      push_leg(s, e, st, 1'b0);
    end
  endfunction

  // -------------------------------------------------------------- driver tasks
  task automatic drive_idle();
    cfg_start_freq = '0; cfg_stop_freq = '0; cfg_step = '0;
    cfg_dwell = '0; cfg_mode = '0;
    start = 1'b0; abort = 1'b0; inc_ready = 1'b0;
  endtask

  // Runs one sweep. Single sweeps run to done; repeat/up-down sweeps are
  // aborted during the dwell after n_acc accepted values. hold_freq >= 0 holds
  // inc_ready low for five cycles the first time that value is offered.
  task automatic run_sweep(input string name, input int s, input int e, input int st,
                           input int dw, input logic [1:0] md, input int n_acc,
                           input int ready_pct, input int hold_freq);
    int dwell_eff, last_acc, budget, hold_left, got, total;
    bit holding, seen_after, busy_drop, done_seen, single;
    logic [FREQ_W-1:0] exp_f, last_f, held;
    single = (md == 2'b00 || md == 2'b11);
    build_model(s, e, st, md, n_acc);
    total = single ? exp_q.size() : n_acc;
    dwell_eff = (dw == 0) ? 1 : dw;
    last_acc = -1; budget = 0; hold_left = 5; got = 0;
    holding = 0; seen_after = 0; busy_drop = 0; done_seen = 0;
    last_f = '0; held = '0;

    @(negedge clk);
    cfg_start_freq = FREQ_W'(s); cfg_stop_freq = FREQ_W'(e); cfg_step = FREQ_W'(st);
    cfg_dwell = DWELL_W'(dw); cfg_mode = md; start = 1'b1; abort = 1'b0; inc_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({name, "_valid_latency"}, 32'(inc_valid), 32'd1);
    check({name, "_busy_start"}, 32'(busy), 32'd1);
    check({name, "_dbg_present"}, 32'(state_dbg), DBG_PRES);

    while (got < total && budget < 20000) begin
      if (!busy) busy_drop = 1'b1;
      if (done) done_seen = 1'b1;
      if (holding) begin
        check({name, "_hold_valid"}, 32'(inc_valid), 32'd1);
        check({name, "_hold_freq"}, 32'(freq_out), 32'(held));
        holding = 1'b0;
      end
      if (inc_valid) begin
        if (last_acc >= 0 && !seen_after) begin
          check({name, "_step_period"}, 32'(cyc - last_acc), 32'(dwell_eff + 1));
          seen_after = 1'b1;
        end
        if (hold_freq >= 0 && int'(freq_out) == hold_freq && hold_left > 0) begin
          inc_ready = 1'b0;
          hold_left--;
        end else begin
          inc_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (inc_ready) begin
          exp_f = exp_q.pop_front();
          check({name, "_freq"}, 32'(freq_out), 32'(exp_f));
          check({name, "_phase_inc"}, 32'(phase_inc), pinc_of(int'(exp_f)));
          got++; last_acc = cyc; seen_after = 1'b0; last_f = exp_f;
        end else begin
          holding = 1'b1;
          held = freq_out;
        end
      end else begin
        inc_ready = 1'($urandom_range(0, 1));
      end
      // Config churn and stray start pulses must not disturb a running sweep.
      cfg_start_freq = FREQ_W'($urandom_range(0, 65535));
      cfg_stop_freq  = FREQ_W'($urandom_range(0, 65535));
      cfg_step       = FREQ_W'($urandom_range(0, 65535));
      cfg_dwell      = DWELL_W'($urandom_range(0, 20));
      cfg_mode       = 2'($urandom_range(0, 3));
      start          = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    inc_ready = 1'b0;
    check({name, "_all_accepted"}, 32'(got), 32'(total));
    check({name, "_dbg_dwell"}, 32'(state_dbg), DBG_DWEL);

    if (single) begin
      while (cyc < last_acc + dwell_eff + 1 && budget < 20000) begin
        if (!busy) busy_drop = 1'b1;
        if (done) done_seen = 1'b1;
        @(negedge clk);
        budget++;
      end
      check({name, "_no_early_done"}, 32'(done_seen), 32'd0);
      check({name, "_busy_held"}, 32'(busy_drop), 32'd0);
      check({name, "_done_pulse"}, 32'(done), 32'd1);
      check({name, "_busy_low_at_done"}, 32'(busy), 32'd0);
      check({name, "_valid_low_at_done"}, 32'(inc_valid), 32'd0);
      check({name, "_freq_kept"}, 32'(freq_out), 32'(last_f));
      check({name, "_pinc_kept"}, 32'(phase_inc), pinc_of(int'(last_f)));
      check({name, "_dbg_idle"}, 32'(state_dbg), DBG_IDLE);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
      check({name, "_stays_idle"}, 32'(busy), 32'd0);
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({name, "_no_done"}, 32'(done_seen), 32'd0);
      check({name, "_busy_held"}, 32'(busy_drop), 32'd0);
      check({name, "_abort_busy"}, 32'(busy), 32'd0);
      check({name, "_abort_valid"}, 32'(inc_valid), 32'd0);
      check({name, "_abort_done"}, 32'(done), 32'd0);
      check({name, "_abort_freq_kept"}, 32'(freq_out), 32'(last_f));
      check({name, "_abort_dbg"}, 32'(state_dbg), DBG_IDLE);
      repeat (3) @(negedge clk);
      check({name, "_abort_stays_idle"}, 32'(inc_valid), 32'd0);
    end
  endtask

  task automatic start_abort_idle();
    @(negedge clk);
    cfg_start_freq = 16'd10; cfg_stop_freq = 16'd50; cfg_step = 16'd5;
    cfg_dwell = 24'd2; cfg_mode = 2'b01; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_valid", 32'(inc_valid), 32'd0);
    check("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("start_abort_still_idle", 32'(inc_valid), 32'd0);
  endtask

  task automatic reset_mid_dwell();
    @(negedge clk);
    cfg_start_freq = 16'd200; cfg_stop_freq = 16'd300; cfg_step = 16'd10;
    cfg_dwell = 24'd8; cfg_mode = 2'b01; start = 1'b1; inc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    inc_ready = 1'b0;
    check("rst_pre_busy", 32'(busy), 32'd1);
    check("rst_pre_freq", 32'(freq_out), 32'd200);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(inc_valid), 32'd0);
    check("rst_async_freq", 32'(freq_out), 32'd0);
    check("rst_async_pinc", 32'(phase_inc), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_idle", 32'(busy), 32'd0);
  endtask

  // ------------------------------------------------------------------ sequence
  initial begin
    int s, e, st, dw;
    logic [1:0] md;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(inc_valid), 32'd0);
    check("reset_freq", 32'(freq_out), 32'd0);
    check("reset_pinc", 32'(phase_inc), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbg", 32'(state_dbg), DBG_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep("single_up",    100, 130, 10, 3, 2'b00, 0, 100, -1);
    run_sweep("clamp_up",     100, 125, 10, 2, 2'b00, 0, 100, -1);
    run_sweep("down",          50,  20, 15, 2, 2'b00, 0, 100, -1);
    run_sweep("down_big",      50,  20, 40, 1, 2'b00, 0, 100, -1);
    run_sweep("mode3_single",  40,  70, 10, 1, 2'b11, 0, 100, -1);
    run_sweep("updown",        10,  30, 10, 2, 2'b10, 9, 100, -1);
    run_sweep("backpressure", 100, 130, 10, 3, 2'b00, 0, 100, 110);
    run_sweep("dwell0",       300, 340, 10, 0, 2'b00, 0, 100, -1);
    run_sweep("step0_single", 500, 900,  0, 2, 2'b00, 0, 100, -1);
    run_sweep("step0_repeat", 500, 900,  0, 1, 2'b01, 4, 100, -1);
    run_sweep("point_updown",  77,  77,  5, 1, 2'b10, 4, 100, -1);
    run_sweep("repeat_25k", 25000, 25000, 100, 4, 2'b01, 4, 100, -1);
    run_sweep("repeat_ramp",   10,  40, 15, 1, 2'b01, 8, 70, -1);
    start_abort_idle();
    reset_mid_dwell();

    for (int i = 0; i < 8; i++) begin
      s  = int'($urandom_range(0, 400));
      e  = int'($urandom_range(0, 400));
      st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(5, 80));
      dw = int'($urandom_range(0, 5));
      md = 2'($urandom_range(0, 3));
      run_sweep("rand", s, e, st, dw, md, 12, 70, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit so a stuck design can never hang the run.
  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
